// File: rtl/sha256d_stream_engine.sv
// Multi-block SHA-256 / SHA-256d engine: streams pre-padded 512-bit blocks through an
// iterative one-round-per-cycle core and chains the intermediate hash across blocks.
module sha256d_stream_engine #(
  parameter int unsigned MAX_BLOCKS = 16,
  parameter int unsigned CNT_W      = $clog2(MAX_BLOCKS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode_double,
  input  logic             abort,
  input  logic [511:0]     blk_data,
  input  logic             blk_last,
  input  logic             blk_valid,
  output logic             blk_ready,
  output logic             busy,
  output logic [255:0]     digest,
  output logic             digest_valid,
  input  logic             digest_ready,
  output logic [CNT_W-1:0] blk_count,
  output logic             err
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_ROUND  = 3'd2;
  localparam logic [2:0] S_UPDATE = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [255:0] IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

  localparam logic [0:63][31:0] K = {
    256'h428a2f98_71374491_b5c0fbcf_e9b5dba5_3956c25b_59f111f1_923f82a4_ab1c5ed5,
    256'hd807aa98_12835b01_243185be_550c7dc3_72be5d74_80deb1fe_9bdc06a7_c19bf174,
    256'he49b69c1_efbe4786_0fc19dc6_240ca1cc_2de92c6f_4a7484aa_5cb0a9dc_76f988da,
    256'h983e5152_a831c66d_b00327c8_bf597fc7_c6e00bf3_d5a79147_06ca6351_14292967,
    256'h27b70a85_2e1b2138_4d2c6dfc_53380d13_650a7354_766a0abb_81c2c92e_92722c85,
    256'ha2bfe8a1_a81a664b_c24b8b70_c76c51a3_d192e819_d6990624_f40e3585_106aa070,
    256'h19a4c116_1e376c08_2748774c_34b0bcb5_391c0cb3_4ed8aa4a_5b9cca4f_682e6ff3,
    256'h748f82ee_78a5636f_84c87814_8cc70208_90befffa_a4506ceb_bef9a3f7_c67178f2
  };

  function automatic logic [31:0] ror(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_s0(input logic [31:0] x);
    return ror(x, 2) ^ ror(x, 13) ^ ror(x, 22);
  endfunction

  function automatic logic [31:0] big_s1(input logic [31:0] x);
    return ror(x, 6) ^ ror(x, 11) ^ ror(x, 25);
  endfunction

  function automatic logic [31:0] small_s0(input logic [31:0] x);
    return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_s1(input logic [31:0] x);
    return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
  endfunction

  logic [2:0]        state, state_next;
  logic [5:0]        rnd;
  logic [0:15][31:0] w;
  logic [0:7][31:0]  hv, wv, hv_sum, wv_round;
  logic              last, dbl, pass;
  logic [31:0]       t1, t2, w_new;
  logic              accept;
  logic [CNT_W-1:0]  count_next;
  logic              err_next, blk_ready_next, busy_next, digest_valid_next;

  // Round function, schedule expansion and chaining sum
  always_comb begin
    t1 = wv[7] + big_s1(wv[4]) + ((wv[4] & wv[5]) ^ (~wv[4] & wv[6])) + K[rnd] + w[0];
    t2 = big_s0(wv[0]) + ((wv[0] & wv[1]) ^ (wv[0] & wv[2]) ^ (wv[1] & wv[2]));
    wv_round = {t1 + t2, wv[0], wv[1], wv[2], wv[3] + t1, wv[4], wv[5], wv[6]};
    w_new = small_s1(w[14]) + w[9] + small_s0(w[1]) + w[0];
    for (int j = 0; j < 8; j++) hv_sum[j] = hv[j] + wv[j];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    count_next = blk_count;
    err_next   = err;
    accept     = 1'b0;
    case (state)
      S_IDLE: if (start) begin
        state_next = S_WAIT;
        count_next = '0;
        err_next   = 1'b0;
      end
      S_WAIT: begin
        if (blk_valid && blk_ready) begin
          accept     = 1'b1;
          state_next = S_ROUND;
          count_next = blk_count + CNT_W'(1);
        end else if (blk_valid && (blk_count == CNT_W'(MAX_BLOCKS))) begin
          err_next = 1'b1;
        end
      end
      S_ROUND:  if (rnd == 6'd63) state_next = S_UPDATE;
      S_UPDATE: begin
        if (!last)              state_next = S_WAIT;
        else if (dbl && !pass)  state_next = S_ROUND;
        else                    state_next = S_DONE;
      end
      S_DONE:   if (digest_ready) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
    // Cancel overrides any handshake or start in the same cycle; err is kept
    if (abort) begin
      state_next = S_IDLE;
      count_next = '0;
      err_next   = err;
      accept     = 1'b0;
    end
    blk_ready_next    = (state_next == S_WAIT) && (count_next < CNT_W'(MAX_BLOCKS));
    busy_next         = (state_next != S_IDLE);
    digest_valid_next = (state_next == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rnd          <= '0;
      w            <= '0;
      hv           <= IV;
      wv           <= '0;
      last         <= 1'b0;
      dbl          <= 1'b0;
      pass         <= 1'b0;
      blk_ready    <= 1'b0;
      busy         <= 1'b0;
      digest       <= '0;
      digest_valid <= 1'b0;
      blk_count    <= '0;
      err          <= 1'b0;
    end else begin
      blk_ready    <= blk_ready_next;
      busy         <= busy_next;
      digest_valid <= digest_valid_next;
      blk_count    <= count_next;
      err          <= err_next;
      if (!abort) begin
        case (state)
          S_IDLE: if (start) begin
            hv   <= IV;
            dbl  <= mode_double;
            pass <= 1'b0;
          end
          S_WAIT: if (accept) begin
            w    <= blk_data;
            wv   <= hv;
            last <= blk_last;
            rnd  <= '0;
          end
          S_ROUND: begin
            wv  <= wv_round;
            w   <= {w[1:15], w_new};
            rnd <= rnd + 6'd1;
          end
          S_UPDATE: begin
            // Second pass hashes the 32-byte digest with its fixed padding
            if (last && dbl && !pass) begin
              w    <= {hv_sum, 1'b1, 191'b0, 64'h100};
              hv   <= IV;
              wv   <= IV;
              pass <= 1'b1;
              rnd  <= '0;
            end else begin
              hv <= hv_sum;
              if (last) digest <= hv_sum;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sha256d_stream_engine.sv
// Scoreboard bench for sha256d_stream_engine: directed known-answer jobs, overflow,
// abort and mid-job reset.
module tb_sha256d_stream_engine;

  localparam int unsigned MAXB = 2;
  localparam int unsigned CW   = $clog2(MAXB + 1);

  localparam logic [511:0] BLK_ABC   = {32'h61626380, 416'h0, 64'h18};
  localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
  localparam logic [511:0] BLK_M1 = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] BLK_M2 = {480'h0, 32'h1c0};

  localparam logic [255:0] D_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] D_ABC2  = 256'h4f8b42c22dd3729b519ba6f68d2da7cc5b2d606d05daed5ad5128cc03e6c6358;
  localparam logic [255:0] D_EMPTY2 = 256'h5df6e0e2761359d30a8275058e299fcc0381534545f55cf43e41983f5d4c9456;
  localparam logic [255:0] D_M     = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  logic          clk = 1'b0;
  logic          rst_n, start, mode_double, abort, blk_last, blk_valid, digest_ready;
  logic [511:0]  blk_data;
  logic          blk_ready, busy, digest_valid, err;
  logic [255:0]  digest;
  logic [CW-1:0] blk_count;

  typedef struct {
    logic [255:0] d;
    int unsigned  cnt;
    int unsigned  due;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  logic        prev_valid = 1'b0;

  sha256d_stream_engine #(.MAX_BLOCKS(MAXB)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode_double(mode_double), .abort(abort),
    .blk_data(blk_data), .blk_last(blk_last), .blk_valid(blk_valid), .blk_ready(blk_ready),
    .busy(busy), .digest(digest), .digest_valid(digest_valid), .digest_ready(digest_ready),
    .blk_count(blk_count), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: compares every presented digest against the scoreboard head
  always @(negedge clk) begin
    if (rst_n && digest_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_digest", 256'(digest_valid), 256'(0));
      end else begin
        if (!prev_valid) chk("latency", 256'(cyc), 256'(sb[0].due));
        chk("digest", digest, sb[0].d);
        if (digest_ready) begin
          chk("blk_count_at_done", 256'(blk_count), 256'(sb[0].cnt));
          void'(sb.pop_front());
        end
      end
    end
    prev_valid = digest_valid;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic dbl);
    start = 1'b1;
    mode_double = dbl;
    step();
    start = 1'b0;
  endtask

  // Offers a block until accepted; c is the cycle stamp of the handshake cycle
  task automatic send_block(input logic [511:0] data, input logic lst, output int unsigned c);
    bit ok = 0;
    c = 0;
    blk_data = data;
    blk_last = lst;
    blk_valid = 1'b1;
    for (int n = 0; n < 400 && !ok; n++) begin
      @(negedge clk);
      if (blk_ready) begin
        ok = 1;
        c = cyc;
      end
    end
    if (!ok) chk("blk_accept_timeout", 256'(blk_ready), 256'(1));
    step();
    blk_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int n = 0; n < 400 && !ok; n++) begin
      @(negedge clk);
      if (!busy) ok = 1;
    end
    if (!ok) chk("idle_timeout", 256'(busy), 256'(0));
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned c;
    bit ok;
    rst_n = 1'b0; start = 1'b0; mode_double = 1'b0; abort = 1'b0;
    blk_data = '0; blk_last = 1'b0; blk_valid = 1'b0; digest_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_blk_ready", 256'(blk_ready), 256'(0));
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_digest_valid", 256'(digest_valid), 256'(0));
    chk("rst_digest", digest, 256'(0));
    chk("rst_blk_count", 256'(blk_count), 256'(0));
    chk("rst_err", 256'(err), 256'(0));
    step();
    rst_n = 1'b1;
    step();

    // Single-block SHA-256 and SHA-256d known answers
    start_job(1'b0);
    send_block(BLK_ABC, 1'b1, c);
    sb.push_back('{D_ABC, 1, c + 66});
    wait_idle();

    start_job(1'b1);
    send_block(BLK_ABC, 1'b1, c);
    sb.push_back('{D_ABC2, 1, c + 131});
    wait_idle();

    start_job(1'b1);
    send_block(BLK_EMPTY, 1'b1, c);
    sb.push_back('{D_EMPTY2, 1, c + 131});
    wait_idle();

    // Two blocks with an offer gap and a stalled consumer
    digest_ready = 1'b0;
    start_job(1'b0);
    send_block(BLK_M1, 1'b0, c);
    repeat (3) step();
    send_block(BLK_M2, 1'b1, c);
    sb.push_back('{D_M, 2, c + 66});
    ok = 0;
    for (int n = 0; n < 300 && !ok; n++) begin
      @(negedge clk);
      if (digest_valid) ok = 1;
    end
    if (!ok) chk("digest_wait_timeout", 256'(digest_valid), 256'(1));
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("hold_valid", 256'(digest_valid), 256'(1));
    step();
    digest_ready = 1'b1;
    wait_idle();

    // Overflow: third block refused, err sticky across abort until next start
    start_job(1'b0);
    send_block(BLK_M1, 1'b0, c);
    send_block(BLK_M1, 1'b0, c);
    blk_data = BLK_M1;
    blk_last = 1'b0;
    blk_valid = 1'b1;
    repeat (80) @(posedge clk);
    @(negedge clk);
    chk("ovf_blk_ready", 256'(blk_ready), 256'(0));
    chk("ovf_err", 256'(err), 256'(1));
    chk("ovf_busy", 256'(busy), 256'(1));
    chk("ovf_blk_count", 256'(blk_count), 256'(2));
    step();
    blk_valid = 1'b0;
    abort = 1'b1;
    step();
    abort = 1'b0;
    @(negedge clk);
    chk("abort_busy", 256'(busy), 256'(0));
    chk("abort_blk_ready", 256'(blk_ready), 256'(0));
    chk("abort_blk_count", 256'(blk_count), 256'(0));
    chk("abort_err_kept", 256'(err), 256'(1));
    step();
    repeat (3) step();
    @(negedge clk);
    chk("err_sticky_idle", 256'(err), 256'(1));
    step();
    start_job(1'b0);
    @(negedge clk);
    chk("start_clears_err", 256'(err), 256'(0));
    chk("start_blk_ready", 256'(blk_ready), 256'(1));
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;

    // Reset in the middle of the rounds of a double job
    start_job(1'b1);
    send_block(BLK_ABC, 1'b1, c);
    repeat (30) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_blk_ready", 256'(blk_ready), 256'(0));
    chk("midrst_busy", 256'(busy), 256'(0));
    chk("midrst_digest_valid", 256'(digest_valid), 256'(0));
    chk("midrst_digest", digest, 256'(0));
    chk("midrst_blk_count", 256'(blk_count), 256'(0));
    step();

    // Abort coinciding with a block handshake
    start_job(1'b0);
    blk_data = BLK_ABC;
    blk_last = 1'b1;
    blk_valid = 1'b1;
    abort = 1'b1;
    step();
    abort = 1'b0;
    blk_valid = 1'b0;
    @(negedge clk);
    chk("abort_hs_busy", 256'(busy), 256'(0));
    chk("abort_hs_blk_ready", 256'(blk_ready), 256'(0));
    chk("abort_hs_blk_count", 256'(blk_count), 256'(0));
    step();
    repeat (100) step();

    start_job(1'b0);
    send_block(BLK_ABC, 1'b1, c);
    sb.push_back('{D_ABC, 1, c + 66});
    wait_idle();
    repeat (5) step();
    chk("scoreboard_drained", 256'(sb.size()), 256'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
